// File: rtl/router_pkg.sv
// Shared state encoding, default sizes and the port-select decode helper
// for the router controller.
package router_pkg;

    localparam int NUM_PORTS_DEF = 3;
    localparam int ADDR_W_DEF    = 2;
    localparam int DATA_W_DEF    = 8;

    // onehot() is sized for the largest supported address field.
    localparam int SEL_AW  = 6;
    localparam int SEL_MAX = 2 ** SEL_AW;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    function automatic logic [SEL_MAX-1:0] onehot(input logic [SEL_AW-1:0] idx);
        logic [SEL_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Saturating cycle counter bounding the time spent waiting for the
// destination FIFO to drain.
module router_wait_timer #(
    parameter int WAIT_TIMEOUT = 30
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int            CW   = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != LAST)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/router_fsm_np.sv
// Router controller: decodes the header, picks the output port, sequences
// FIFO loading, and drops bad-address or timed-out packets.
module router_fsm_np
    import router_pkg::*;
#(
    parameter int NUM_PORTS    = NUM_PORTS_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int WAIT_TIMEOUT = 30
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 full_state,
    output logic                 laf_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [ADDR_W-1:0]    port_sel,
    output logic [NUM_PORTS-1:0] fifo_sel,
    output logic                 drop_pkt,
    output logic                 wait_timeout
);

    localparam int NSEL = 2 ** ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   port_sel_q, port_sel_d, addr;
    logic                wait_to_q, wait_to_d;
    logic [NSEL-1:0]     full_pad, empty_pad, srst_pad;
    logic                full_sel, empty_sel, srst_hit, addr_ok, tc;
    logic                unused_data;

    // Zero-extend per-port vectors so unpopulated addresses read as 0.
    assign full_pad    = NSEL'(fifo_full);
    assign empty_pad   = NSEL'(fifo_empty);
    assign srst_pad    = NSEL'(soft_reset);
    assign addr        = data_in[ADDR_W-1:0];
    assign addr_ok     = int'(addr) < NUM_PORTS;
    assign full_sel    = full_pad[port_sel_q];
    assign empty_sel   = empty_pad[port_sel_q];
    assign srst_hit    = (state_q != DECODE_ADDRESS) && srst_pad[port_sel_q];
    assign unused_data = ^data_in;

    router_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_timer (
        .clock  (clock),
        .resetn (resetn),
        .clr_i  ((state_q != WAIT_TILL_EMPTY) || srst_hit),
        .en_i   (!empty_sel),
        .tc_o   (tc)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= DECODE_ADDRESS;
            port_sel_q <= '0;
            wait_to_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_sel_q <= port_sel_d;
            wait_to_q  <= wait_to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        port_sel_d = port_sel_q;
        if (srst_hit) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: if (pkt_valid) begin
                    port_sel_d = addr;
                    if (!addr_ok)              state_d = DROP_PACKET;
                    else if (empty_pad[addr])  state_d = LOAD_FIRST_DATA;
                    else                       state_d = WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (full_sel)        state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                end
                FIFO_FULL_STATE: if (!full_sel) state_d = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_d = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = LOAD_PARITY;
                    else                    state_d = LOAD_DATA;
                end
                LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_d = full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY: begin
                    if (empty_sel) state_d = LOAD_FIRST_DATA;
                    else if (tc)   state_d = DROP_PACKET;
                end
                DROP_PACKET: if (!pkt_valid) state_d = DECODE_ADDRESS;
                default:     state_d = DECODE_ADDRESS;
            endcase
        end
        wait_to_d = (state_q == WAIT_TILL_EMPTY) && (state_d == DROP_PACKET);
    end

    always_comb begin
        detect_add    = (state_q == DECODE_ADDRESS);
        lfd_state     = (state_q == LOAD_FIRST_DATA);
        ld_state      = (state_q == LOAD_DATA);
        full_state    = (state_q == FIFO_FULL_STATE);
        laf_state     = (state_q == LOAD_AFTER_FULL);
        rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        drop_pkt      = (state_q == DROP_PACKET);
        write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                        (state_q == LOAD_PARITY);
        busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA) ||
                          (state_q == DROP_PACKET));
        port_sel      = port_sel_q;
        fifo_sel      = NUM_PORTS'(onehot(SEL_AW'(port_sel_q)));
        if (detect_add || drop_pkt)
            fifo_sel = '0;
        wait_timeout  = wait_to_q;
    end

endmodule

// File: tb/tb_router_fsm_np.sv
// Randomised + directed bench for router_fsm_np against a packet-level
// behavioural model of the controller.
module tb_router_fsm_np;

    localparam int NP = 3, AW = 2, DW = 8, WT = 30;

    logic          clock = 1'b0;
    logic          resetn, pkt_valid, parity_done, low_pkt_valid;
    logic [DW-1:0] data_in;
    logic [NP-1:0] fifo_full, fifo_empty, soft_reset;
    logic          detect_add, lfd_state, ld_state, full_state, laf_state;
    logic          rst_int_reg, write_enb_reg, busy, drop_pkt, wait_timeout;
    logic [AW-1:0] port_sel;
    logic [NP-1:0] fifo_sel;

    router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .WAIT_TIMEOUT(WT)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .port_sel(port_sel),
        .fifo_sel(fifo_sel), .drop_pkt(drop_pkt), .wait_timeout(wait_timeout)
    );

    always #5 clock = ~clock;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: packet phase, chosen port, cycles already waited, pending timeout pulse.
    typedef enum int {M_IDLE, M_HDR, M_BODY, M_STALL, M_RESUME, M_PAR, M_CHK, M_WAIT, M_DROP} mph_t;
    mph_t m_st, n_st;
    int   m_port, n_port, m_waited, n_waited;
    bit   m_to, n_to;

    int wen_seen, wait_seen, to_seen, drop_seen;

    task automatic clr_obs();
        wen_seen = 0; wait_seen = 0; to_seen = 0; drop_seen = 0;
    endtask

    task automatic model_step();
        int a;
        bit fs, es;
        a  = int'(data_in[AW-1:0]);
        fs = (m_port < NP) ? fifo_full[m_port]  : 1'b0;
        es = (m_port < NP) ? fifo_empty[m_port] : 1'b0;
        n_st = m_st; n_port = m_port; n_waited = m_waited; n_to = 1'b0;
        if (!resetn) begin
            n_st = M_IDLE; n_port = 0; n_waited = 0;
        end else if (m_st != M_IDLE && m_port < NP && soft_reset[m_port]) begin
            n_st = M_IDLE; n_waited = 0;
        end else begin
            case (m_st)
                M_IDLE: if (pkt_valid) begin
                    n_port = a;
                    if (a >= NP)            n_st = M_DROP;
                    else if (fifo_empty[a]) n_st = M_HDR;
                    else begin n_st = M_WAIT; n_waited = 0; end
                end
                M_HDR:    n_st = M_BODY;
                M_BODY:   if (fs) n_st = M_STALL; else if (!pkt_valid) n_st = M_PAR;
                M_STALL:  if (!fs) n_st = M_RESUME;
                M_RESUME: n_st = parity_done ? M_IDLE : (low_pkt_valid ? M_PAR : M_BODY);
                M_PAR:    n_st = M_CHK;
                M_CHK:    n_st = fs ? M_STALL : M_IDLE;
                M_WAIT: begin
                    if (es) n_st = M_HDR;
                    else if (m_waited == WT - 1) begin n_st = M_DROP; n_to = 1'b1; end
                    else n_waited = m_waited + 1;
                end
                M_DROP:   if (!pkt_valid) n_st = M_IDLE;
                default:  n_st = M_IDLE;
            endcase
        end
    endtask

    // Check current outputs, then advance one clock with the inputs already driven.
    task automatic cycle();
        logic [9:0]    act, exp;
        logic [NP-1:0] fs_exp;
        act = {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
               write_enb_reg, busy, drop_pkt, wait_timeout};
        exp = {m_st == M_IDLE, m_st == M_HDR, m_st == M_BODY, m_st == M_STALL,
               m_st == M_RESUME, m_st == M_CHK, m_st inside {M_BODY, M_RESUME, M_PAR},
               !(m_st inside {M_IDLE, M_BODY, M_DROP}), m_st == M_DROP, m_to};
        fs_exp = '0;
        if (!(m_st inside {M_IDLE, M_DROP}) && m_port < NP) fs_exp[m_port] = 1'b1;
        chk("strobes", 32'(act), 32'(exp));
        chk("port_sel", 32'(port_sel), 32'(m_port));
        chk("fifo_sel", 32'(fifo_sel), 32'(fs_exp));
        if (write_enb_reg) wen_seen++;
        if (busy && !lfd_state && !full_state && !laf_state && !rst_int_reg && !write_enb_reg)
            wait_seen++;
        if (wait_timeout) to_seen++;
        if (drop_pkt) drop_seen++;
        model_step();
        @(posedge clock);
        #1;
        m_st = n_st; m_port = n_port; m_waited = n_waited; m_to = n_to;
    endtask

    task automatic idle_inputs();
        resetn = 1'b1; pkt_valid = 1'b0; data_in = '0; fifo_full = '0; fifo_empty = '1;
        soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    task automatic hdr(input logic [DW-1:0] h);
        pkt_valid = 1'b1; data_in = h; cycle();
    endtask

    task automatic body(input int n);
        for (int i = 0; i < n; i++) begin
            pkt_valid = 1'b1; data_in = DW'($urandom); cycle();
        end
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        @(posedge clock);
        #1;
        m_st = M_IDLE; m_port = 0; m_waited = 0; m_to = 1'b0;
        resetn = 1'b1;
        clr_obs();

        // Clean packet to port 1.
        hdr(8'h05); body(1); body(4);
        pkt_valid = 1'b0; data_in = 8'hA5; cycle();
        cycle(); cycle(); cycle();
        chk("s1_writes", 32'(wen_seen), 32'd6);

        // Port 2 busy, drains after 10 cycles of waiting.
        clr_obs();
        fifo_empty = 3'b011;
        hdr(8'h02);
        for (int i = 0; i < 9; i++) cycle();
        fifo_empty = 3'b111; cycle();
        body(3); pkt_valid = 1'b0; cycle(); cycle(); cycle();
        chk("s2_wait_cycles", 32'(wait_seen), 32'd10);
        chk("s2_no_timeout", 32'(to_seen), 32'd0);

        // Port 0 never drains: timeout then drop.
        clr_obs();
        fifo_empty = 3'b110;
        hdr(8'h10);
        for (int i = 0; i < WT; i++) cycle();
        body(4); pkt_valid = 1'b0; cycle(); cycle();
        chk("s3_wait_cycles", 32'(wait_seen), 32'(WT));
        chk("s3_timeout_pulses", 32'(to_seen), 32'd1);
        chk("s3_no_writes", 32'(wen_seen), 32'd0);
        chk("s3_drop_cycles", 32'(drop_seen), 32'd5);
        chk("s3_back_idle", 32'(detect_add), 32'd1);

        // Invalid address 3.
        clr_obs();
        fifo_empty = 3'b111;
        hdr(8'h03); body(2); pkt_valid = 1'b0; cycle(); cycle();
        chk("s4_drop_cycles", 32'(drop_seen), 32'd3);

        // Full stall then resume, once via low_pkt_valid and once via parity_done.
        for (int r = 0; r < 2; r++) begin
            hdr(8'h01); body(2);
            fifo_full = 3'b010; body(1); body(1);
            fifo_full = 3'b000; pkt_valid = 1'b0;
            low_pkt_valid = (r == 0); parity_done = (r == 1);
            cycle(); cycle();
            low_pkt_valid = 1'b0; parity_done = 1'b0;
            cycle(); cycle(); cycle();
        end

        // Soft reset on another port, then on the selected port, then hard reset.
        hdr(8'h01); body(2);
        soft_reset = 3'b100; body(1);
        soft_reset = 3'b010; body(1);
        soft_reset = 3'b000; pkt_valid = 1'b0; cycle();
        hdr(8'h01); body(2);
        resetn = 1'b0; body(1);
        resetn = 1'b1; pkt_valid = 1'b0; cycle(); cycle();

        // Randomised traffic.
        idle_inputs();
        for (int c = 0; c < 4000; c++) begin
            resetn        = ($urandom_range(199) != 0);
            pkt_valid     = ($urandom_range(3) != 0);
            data_in       = DW'($urandom);
            parity_done   = ($urandom_range(7) == 0);
            low_pkt_valid = ($urandom_range(7) == 0);
            for (int b = 0; b < NP; b++) begin
                fifo_full[b]  = ($urandom_range(7) == 0);
                soft_reset[b] = ($urandom_range(59) == 0);
                if ($urandom_range(39) == 0) fifo_empty[b] = ~fifo_empty[b];
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
